// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath width, PC vectors and PC-unit FSM states.
package cpu_pkg;

   localparam int          CPU_XLEN      = 32;
   localparam logic [31:0] CPU_RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] CPU_TRAP_VEC  = 32'h0000_0100;
   localparam int          CPU_INC       = 4;

   typedef enum logic {
      PC_RUN  = 1'b0,
      PC_HALT = 1'b1
   } pc_state_e;

endpackage

// File: rtl/pc_target_sel.sv
// Redirect target selection: computes the branch, JAL and JALR targets,
// picks one by priority (JALR > JAL > branch), and flags a misaligned pick.
module pc_target_sel
   import cpu_pkg::*;
#(
   parameter int XLEN = CPU_XLEN
) (
   input  logic              [XLEN-1:0] i_pc,
   input  logic                         i_branch_taken,
   input  logic signed       [XLEN-1:0] i_branch_off,
   input  logic                         i_jal,
   input  logic signed       [XLEN-1:0] i_jal_off,
   input  logic                         i_jalr,
   input  logic              [XLEN-1:0] i_jalr_base,
   input  logic signed       [XLEN-1:0] i_jalr_off,
   output logic                         o_redirect,
   output logic              [XLEN-1:0] o_target,
   output logic                         o_misaligned
);

   // Two's-complement addition is identical for signed and unsigned operands
   // modulo 2^XLEN, so the offsets are reinterpreted and wrap silently.
   logic [XLEN-1:0] branch_tgt;
   logic [XLEN-1:0] jal_tgt;
   logic [XLEN-1:0] jalr_sum;

   assign branch_tgt = i_pc + $unsigned(i_branch_off);
   assign jal_tgt    = i_pc + $unsigned(i_jal_off);
   assign jalr_sum   = i_jalr_base + $unsigned(i_jalr_off);

   // Priority mux over the redirect sources; bit0 of the JALR target is cleared.
   always_comb begin
      o_redirect = 1'b1;
      o_target   = '0;
      if (i_jalr) begin
         o_target = {jalr_sum[XLEN-1:1], 1'b0};
      end else if (i_jal) begin
         o_target = jal_tgt;
      end else if (i_branch_taken) begin
         o_target = branch_tgt;
      end else begin
         o_redirect = 1'b0;
      end
   end

   // Only a real redirect can fault; the sequential increment is never checked.
   assign o_misaligned = o_redirect && (o_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: sequential fetch, branch/JAL/JALR redirect,
// EBREAK halt with external resume, stall, and misaligned-target trap.
module pc_unit
   import cpu_pkg::*;
#(
   parameter int              XLEN      = CPU_XLEN,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(CPU_RESET_VEC),
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(CPU_TRAP_VEC),
   parameter int              INC       = CPU_INC
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_stall,
   input  logic                   i_branch_taken,
   input  logic signed [XLEN-1:0] i_branch_off,
   input  logic                   i_jal,
   input  logic signed [XLEN-1:0] i_jal_off,
   input  logic                   i_jalr,
   input  logic        [XLEN-1:0] i_jalr_base,
   input  logic signed [XLEN-1:0] i_jalr_off,
   input  logic                   i_ebreak,
   input  logic                   i_resume,
   output logic        [XLEN-1:0] o_pc,
   output logic        [XLEN-1:0] o_pc_link,
   output logic                   o_halted,
   output logic                   o_trap,
   output logic        [XLEN-1:0] o_epc
);

   localparam logic [XLEN-1:0] INC_V = XLEN'(INC);

   pc_state_e       state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            halted_q, halted_d;
   logic            trap_q, trap_d;
   logic [XLEN-1:0] epc_q, epc_d;

   logic            redirect;
   logic [XLEN-1:0] target;
   logic            misaligned;

   pc_target_sel #(
      .XLEN (XLEN)
   ) u_target_sel (
      .i_pc           (pc_q),
      .i_branch_taken (i_branch_taken),
      .i_branch_off   (i_branch_off),
      .i_jal          (i_jal),
      .i_jal_off      (i_jal_off),
      .i_jalr         (i_jalr),
      .i_jalr_base    (i_jalr_base),
      .i_jalr_off     (i_jalr_off),
      .o_redirect     (redirect),
      .o_target       (target),
      .o_misaligned   (misaligned)
   );

   // Next-state logic: stall > ebreak > redirect (trap or jump) > increment in RUN;
   // in HALT only resume matters and it steps past the EBREAK.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      halted_d = halted_q;
      trap_d   = 1'b0;
      epc_d    = epc_q;
      case (state_q)
         PC_RUN: begin
            if (i_stall) begin
               pc_d = pc_q;
            end else if (i_ebreak) begin
               state_d  = PC_HALT;
               halted_d = 1'b1;
            end else if (redirect) begin
               if (misaligned) begin
                  pc_d   = TRAP_VEC;
                  epc_d  = pc_q;
                  trap_d = 1'b1;
               end else begin
                  pc_d = target;
               end
            end else begin
               pc_d = pc_q + INC_V;
            end
         end
         PC_HALT: begin
            if (i_resume) begin
               state_d  = PC_RUN;
               halted_d = 1'b0;
               pc_d     = pc_q + INC_V;
            end
         end
         default: begin
            state_d  = PC_RUN;
            halted_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset overrides everything, including HALT and a trap pulse.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= PC_RUN;
         pc_q     <= RESET_VEC;
         halted_q <= 1'b0;
         trap_q   <= 1'b0;
         epc_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         halted_q <= halted_d;
         trap_q   <= trap_d;
         epc_q    <= epc_d;
      end
   end

   assign o_pc      = pc_q;
   assign o_pc_link = pc_q + INC_V;
   assign o_halted  = halted_q;
   assign o_trap    = trap_q;
   assign o_epc     = epc_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the PC rules.
module tb_pc_unit;

   localparam logic [31:0] RST_VEC = 32'h0000_0000;
   localparam logic [31:0] TRP_VEC = 32'h0000_0100;

   logic               clk = 1'b0;
   logic               rst;
   logic               stall;
   logic               bt;
   logic signed [31:0] boff;
   logic               jal;
   logic signed [31:0] joff;
   logic               jalr;
   logic        [31:0] jbase;
   logic signed [31:0] jroff;
   logic               ebreak;
   logic               resume;
   logic        [31:0] pc;
   logic        [31:0] pc_link;
   logic               halted;
   logic               trap;
   logic        [31:0] epc;

   // behavioural model state
   logic [31:0] m_pc;
   logic        m_halted;
   logic        m_trap;
   logic [31:0] m_epc;

   int n_tests = 0;
   int n_fail  = 0;

   pc_unit dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_stall        (stall),
      .i_branch_taken (bt),
      .i_branch_off   (boff),
      .i_jal          (jal),
      .i_jal_off      (joff),
      .i_jalr         (jalr),
      .i_jalr_base    (jbase),
      .i_jalr_off     (jroff),
      .i_ebreak       (ebreak),
      .i_resume       (resume),
      .o_pc           (pc),
      .o_pc_link      (pc_link),
      .o_halted       (halted),
      .o_trap         (trap),
      .o_epc          (epc)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      rst = 0; stall = 0; bt = 0; boff = 0; jal = 0; joff = 0;
      jalr = 0; jbase = 0; jroff = 0; ebreak = 0; resume = 0;
   endtask

   // Reference model of one clock edge, written from the PC rules directly.
   task automatic model_clock();
      logic [31:0] tgt;
      bit          has_tgt;
      has_tgt = 0;
      tgt     = 0;
      if (rst) begin
         m_pc = RST_VEC; m_halted = 0; m_trap = 0; m_epc = 0;
         return;
      end
      m_trap = 0;
      if (m_halted) begin
         if (resume) begin m_halted = 0; m_pc = m_pc + 4; end
         return;
      end
      if (stall) return;
      if (ebreak) begin m_halted = 1; return; end
      if (jalr)    begin tgt = (jbase + jroff) & ~32'd1; has_tgt = 1; end
      else if (jal) begin tgt = m_pc + joff; has_tgt = 1; end
      else if (bt)  begin tgt = m_pc + boff; has_tgt = 1; end
      if (!has_tgt) m_pc = m_pc + 4;
      else if ((tgt % 4) != 0) begin m_epc = m_pc; m_pc = TRP_VEC; m_trap = 1; end
      else m_pc = tgt;
   endtask

   // One clock: inputs already applied; model follows the edge; outputs settle 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   // Jump to an aligned address with a single JAL.
   task automatic goto_pc(input logic [31:0] dest);
      idle_inputs();
      jal = 1; joff = dest - m_pc;
      step();
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1; jal = 1; joff = 32'h40;
      step(); step();
      n_tests++; if (pc !== RST_VEC) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, RST_VEC); end
      n_tests++; if ({halted, trap} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b exp 00", {halted, trap}); end
      n_tests++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h exp 0", epc); end
      idle_inputs();
      step();
      n_tests++; if (pc !== 32'h4) begin n_fail++; $display("FAIL seq_pc1 got %h exp 4", pc); end
      step();
      n_tests++; if (pc !== 32'h8) begin n_fail++; $display("FAIL seq_pc2 got %h exp 8", pc); end
      step();
      n_tests++; if (pc !== 32'hC) begin n_fail++; $display("FAIL seq_pc3 got %h exp c", pc); end
      n_tests++; if (pc_link !== 32'h10) begin n_fail++; $display("FAIL seq_link got %h exp 10", pc_link); end
   endtask

   task automatic test_branch_stall();
      goto_pc(32'h20);
      n_tests++; if (pc !== 32'h20) begin n_fail++; $display("FAIL goto_20 got %h exp 20", pc); end
      stall = 1; bt = 1; boff = 32'hFFFF_FFF8; ebreak = 1; jalr = 1; jbase = 32'h3;
      step();
      n_tests++; if (pc !== 32'h20 || halted !== 1'b0 || trap !== 1'b0) begin
         n_fail++; $display("FAIL stall_hold pc %h h %b t %b exp 20 0 0", pc, halted, trap); end
      idle_inputs();
      bt = 1; boff = 32'hFFFF_FFF8;
      step();
      n_tests++; if (pc !== 32'h18) begin n_fail++; $display("FAIL branch_back got %h exp 18", pc); end
      boff = 32'h2;
      step();
      n_tests++; if (pc !== TRP_VEC || trap !== 1'b1 || epc !== 32'h18) begin
         n_fail++; $display("FAIL branch_misal pc %h t %b epc %h exp 100 1 18", pc, trap, epc); end
      idle_inputs();
   endtask

   task automatic test_jalr_trap();
      goto_pc(32'h40);
      jalr = 1; jbase = 32'h101; jroff = 32'h2; jal = 1; joff = 32'h80;
      step();
      n_tests++; if (pc !== 32'h100 || trap !== 1'b1 || epc !== 32'h40) begin
         n_fail++; $display("FAIL jalr_trap pc %h t %b epc %h exp 100 1 40", pc, trap, epc); end
      idle_inputs();
      step();
      n_tests++; if (pc !== 32'h104 || trap !== 1'b0 || epc !== 32'h40) begin
         n_fail++; $display("FAIL trap_pulse_end pc %h t %b epc %h exp 104 0 40", pc, trap, epc); end
      goto_pc(32'h40);
      jal = 1; joff = 32'h80; bt = 1; boff = 32'h8;
      step();
      n_tests++; if (pc !== 32'hC0 || trap !== 1'b0) begin
         n_fail++; $display("FAIL jal_wins pc %h t %b exp c0 0", pc, trap); end
      idle_inputs();
      jalr = 1; jbase = 32'h1FF; jroff = 32'h1; jal = 1; joff = 32'h3;
      step();
      n_tests++; if (pc !== 32'h200 || trap !== 1'b0) begin
         n_fail++; $display("FAIL jalr_wins pc %h t %b exp 200 0", pc, trap); end
      idle_inputs();
   endtask

   task automatic test_ebreak_resume();
      goto_pc(32'h50);
      ebreak = 1;
      step();
      n_tests++; if (halted !== 1'b1 || pc !== 32'h50) begin
         n_fail++; $display("FAIL ebreak_halt h %b pc %h exp 1 50", halted, pc); end
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         jal = 1; joff = 32'h100; ebreak = 1; stall = i[0]; jalr = i[1]; jbase = 32'h7;
         step();
         n_tests++; if (halted !== 1'b1 || pc !== 32'h50 || trap !== 1'b0) begin
            n_fail++; $display("FAIL halt_hold[%0d] h %b pc %h t %b exp 1 50 0", i, halted, pc, trap); end
      end
      idle_inputs();
      resume = 1;
      step();
      n_tests++; if (halted !== 1'b0 || pc !== 32'h54) begin
         n_fail++; $display("FAIL resume h %b pc %h exp 0 54", halted, pc); end
      step();
      n_tests++; if (halted !== 1'b0 || pc !== 32'h58) begin
         n_fail++; $display("FAIL resume_in_run h %b pc %h exp 0 58", halted, pc); end
      idle_inputs();
   endtask

   task automatic test_wrap_and_reset();
      goto_pc(32'hFFFF_FFFC);
      n_tests++; if (pc_link !== 32'h0) begin n_fail++; $display("FAIL wrap_link got %h exp 0", pc_link); end
      step();
      n_tests++; if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc got %h exp 0", pc); end
      goto_pc(32'h300);
      ebreak = 1;
      step();
      idle_inputs();
      rst = 1; resume = 1;
      step();
      n_tests++; if (pc !== RST_VEC || halted !== 1'b0) begin
         n_fail++; $display("FAIL reset_in_halt pc %h h %b exp 0 0", pc, halted); end
      idle_inputs();
      jalr = 1; jbase = 32'h2;
      step();
      n_tests++; if (trap !== 1'b1) begin n_fail++; $display("FAIL trap_before_rst got %b exp 1", trap); end
      rst = 1;
      step();
      n_tests++; if (trap !== 1'b0 || pc !== RST_VEC || epc !== 32'h0) begin
         n_fail++; $display("FAIL reset_on_trap t %b pc %h epc %h exp 0 0 0", trap, pc, epc); end
      idle_inputs();
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         rst    = ($urandom_range(0, 49) == 0);
         stall  = ($urandom_range(0, 5) == 0);
         ebreak = ($urandom_range(0, 11) == 0);
         resume = ($urandom_range(0, 2) == 0);
         bt     = ($urandom_range(0, 3) == 0);
         jal    = ($urandom_range(0, 5) == 0);
         jalr   = ($urandom_range(0, 7) == 0);
         boff   = $signed(32'($urandom_range(0, 127)) - 32'd64);
         joff   = $signed(($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255)) << 2);
         jbase  = $urandom;
         jroff  = $signed(32'($urandom_range(0, 15)));
         if ($urandom_range(0, 1) == 0) jbase = jbase & ~32'd3;
         step();
         n_tests++;
         if ({pc, pc_link, halted, trap, epc} !== {m_pc, m_pc + 32'd4, m_halted, m_trap, m_epc}) begin
            n_fail++;
            if (errs < 10)
               $display("FAIL rand[%0d] pc %h link %h h %b t %b epc %h exp pc %h h %b t %b epc %h",
                        i, pc, pc_link, halted, trap, epc, m_pc, m_halted, m_trap, m_epc);
            errs++;
         end
      end
      idle_inputs();
   endtask

   initial begin
      m_pc = 0; m_halted = 0; m_trap = 0; m_epc = 0;
      idle_inputs();
      test_reset();
      test_branch_stall();
      test_jalr_trap();
      test_ebreak_resume();
      test_wrap_and_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
